exibe_sequencia: RTL
====================

EXIBE_SEQUENCIA -- requirements
Module: exibe_sequencia

Interface
REQ-001 Parameter T_ON, default 1000, cycles each sequence item is lit (1 s at 1 kHz clock); legal range 1..65535.
REQ-002 Parameter T_OFF, default 500, cycles LEDs stay dark between items; legal range 1..65535.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 iniciar  input  1  level request to start presenting the sequence.
REQ-006 limite  input  4  index of the last item to present (items 0..limite are shown).
REQ-007 dado  input  4  item read from the sequence memory at address endereco; combinational read, valid in the same cycle.
REQ-008 endereco  output  4  registered memory address of the current item.
REQ-009 leds  output  4  pattern shown to the player.
REQ-010 ativo  output  1  high while a presentation is in progress.
REQ-011 pronto  output  1  one-cycle pulse marking the end of a presentation.
REQ-012 db_estado  output  4  current FSM state code, for the hexa7seg display.

Function
REQ-013 FSM states and codes: INICIAL=0, PREPARA=1, MOSTRA=2, APAGA=3, PROXIMO=4, FIM=5; the remaining codes are unreachable and SHALL return to INICIAL on the next edge.
REQ-014 INICIAL: when iniciar=1, go to PREPARA, latch limite into lim_r and clear endereco and the timer; when iniciar=0, stay.
REQ-015 PREPARA: lasts one cycle, then MOSTRA.
REQ-016 MOSTRA: leds=dado and the 16-bit timer increments each cycle; when timer=T_ON-1, clear the timer and go to APAGA, giving exactly T_ON cycles in MOSTRA.
REQ-017 APAGA: leds=0 and the timer increments; when timer=T_OFF-1, clear the timer and go to FIM if endereco=lim_r, else go to PROXIMO.
REQ-018 PROXIMO: lasts one cycle, endereco increments by 1, then MOSTRA.
REQ-019 FIM: lasts one cycle with pronto=1, then INICIAL.
REQ-020 leds=0 in every state except MOSTRA; leds is a combinational function of the state and dado.
REQ-021 ativo=1 in PREPARA, MOSTRA, APAGA and PROXIMO; ativo=0 in INICIAL and FIM.
REQ-022 Latency: with iniciar sampled at cycle 0, MOSTRA for item 0 begins at cycle 2, and pronto is high in cycle 2+N*(T_ON+T_OFF)+(N-1), where N=lim_r+1.
REQ-023 iniciar is ignored outside INICIAL, and a change of limite during a presentation has no effect because lim_r is latched.
REQ-024 limite=0 presents exactly one item; limite=15 presents 16 items, and endereco never wraps past 15.
REQ-025 If iniciar is held high, a new presentation starts from INICIAL one cycle after FIM.

Reset
REQ-026 While reset=1, on each edge: state=INICIAL, endereco=0, timer=0, lim_r=0.
REQ-027 After reset the outputs SHALL be leds=0, ativo=0, pronto=0 and db_estado=0.
REQ-028 Reset SHALL take priority over iniciar and over all timer events, including when asserted mid-presentation.

Verification (T_ON=4, T_OFF=2)
REQ-029 reset, limite=2, iniciar pulse at cycle 0 -> leds=dado[0] in cycles 2-5, dado[1] in cycles 9-12, dado[2] in cycles 16-19, leds=0 elsewhere; endereco increments in cycles 8 and 15; pronto=1 only in cycle 22.
REQ-030 limite=0, iniciar pulse -> item 0 shown in cycles 2-5, pronto=1 in cycle 8, endereco stays 0.
REQ-031 limite=15 with memory of 16 distinct values -> all 16 values shown in order, endereco ends at 15, pronto=1 in cycle 2+16*6+15=113.
REQ-032 limite changed 2->7 and iniciar pulsed during cycle 10 -> output identical to the REQ-029 scenario.
REQ-033 reset=1 in cycle 11 (during MOSTRA of item 1) -> from cycle 12: leds=0, endereco=0, ativo=0, db_estado=0, and no pronto pulse.
REQ-034 iniciar held high continuously with limite=1 -> pronto pulses repeat with a period of 2+2*6+1+1=16 cycles, each presentation starting from endereco=0.

Source files
------------

// File: rtl/exibe_sequencia_if.sv
// -----------------------------------------------------------------------------
// exibe_sequencia_if
// Purpose : read port between the sequence presenter and the sequence memory.
// Signals :
//   endereco  address of the item currently presented (driven by the presenter)
//   dado      item stored at endereco; combinational read, valid in the same
//             cycle the address is presented (driven by the memory)
// Modports:
//   master  presenter side (drives endereco, reads dado)
//   slave   memory side    (reads endereco, drives dado)
// -----------------------------------------------------------------------------
interface exibe_sequencia_if;
  logic [3:0] endereco;
  logic [3:0] dado;

  modport master (output endereco, input dado);
  modport slave  (input endereco, output dado);
endinterface

// File: rtl/exibe_sequencia.sv
// -----------------------------------------------------------------------------
// exibe_sequencia
// Purpose : presents the items 0..limite of a sequence memory on four LEDs.
//           Each item is lit for T_ON cycles and followed by T_OFF dark cycles.
// Parameters:
//   T_ON   cycles each item is lit          (1..65535)
//   T_OFF  dark cycles between items        (1..65535)
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous, active-high reset
//   iniciar    level request to start a presentation
//   limite     index of the last item to present
//   mem        memory read port (endereco out, dado in)
//   leds       pattern shown to the player (dado while lit, 0 otherwise)
//   ativo      high while a presentation is in progress
//   pronto     one-cycle pulse marking the end of a presentation
//   db_estado  current FSM state code
//
// Handshake: iniciar is a level request that is only looked at in INICIAL;
// everywhere else it is ignored. Completion is signalled by a single-cycle
// pronto pulse in FIM. If iniciar is still high when the FSM is back in
// INICIAL, a new presentation starts immediately.
// -----------------------------------------------------------------------------
module exibe_sequencia #(
  parameter int T_ON  = 1000,
  parameter int T_OFF = 500
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      iniciar,
  input  logic [3:0]                limite,
  exibe_sequencia_if.master         mem,
  output logic [3:0]                leds,
  output logic                      ativo,
  output logic                      pronto,
  output logic [3:0]                db_estado
);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    PREPARA = 4'd1,
    MOSTRA  = 4'd2,
    APAGA   = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } estado_t;

  // Terminal counts; the timer counts 0..T-1 so each phase lasts exactly T cycles.
  localparam logic [15:0] TON_LAST  = 16'(T_ON - 1);
  localparam logic [15:0] TOFF_LAST = 16'(T_OFF - 1);

  estado_t     r_estado;
  estado_t     w_prox_estado;
  logic [15:0] r_timer;
  logic [15:0] w_prox_timer;
  logic [3:0]  r_endereco;
  logic [3:0]  w_prox_endereco;
  logic [3:0]  r_lim;
  logic [3:0]  w_prox_lim;

  // State and datapath registers; reset wins over every other event.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado   <= INICIAL;
      r_timer    <= 16'd0;
      r_endereco <= 4'd0;
      r_lim      <= 4'd0;
    end else begin
      r_estado   <= w_prox_estado;
      r_timer    <= w_prox_timer;
      r_endereco <= w_prox_endereco;
      r_lim      <= w_prox_lim;
    end
  end

  // Next-state, datapath updates and Moore outputs.
  always_comb begin
    w_prox_estado   = INICIAL;
    w_prox_timer    = r_timer;
    w_prox_endereco = r_endereco;
    w_prox_lim      = r_lim;
    leds            = 4'd0;
    ativo           = 1'b0;
    pronto          = 1'b0;

    case (r_estado)
      INICIAL: begin
        if (iniciar) begin
          // limite is captured here so later changes cannot alter the run.
          w_prox_estado   = PREPARA;
          w_prox_lim      = limite;
          w_prox_endereco = 4'd0;
          w_prox_timer    = 16'd0;
        end else begin
          w_prox_estado = INICIAL;
        end
      end

      PREPARA: begin
        ativo         = 1'b1;
        w_prox_estado = MOSTRA;
      end

      MOSTRA: begin
        ativo = 1'b1;
        leds  = mem.dado;
        if (r_timer == TON_LAST) begin
          w_prox_timer  = 16'd0;
          w_prox_estado = APAGA;
        end else begin
          w_prox_timer  = r_timer + 16'd1;
          w_prox_estado = MOSTRA;
        end
      end

      APAGA: begin
        ativo = 1'b1;
        if (r_timer == TOFF_LAST) begin
          w_prox_timer  = 16'd0;
          w_prox_estado = (r_endereco == r_lim) ? FIM : PROXIMO;
        end else begin
          w_prox_timer  = r_timer + 16'd1;
          w_prox_estado = APAGA;
        end
      end

      PROXIMO: begin
        // Only reached while r_endereco < r_lim <= 15, so this never wraps.
        ativo           = 1'b1;
        w_prox_endereco = r_endereco + 4'd1;
        w_prox_estado   = MOSTRA;
      end

      FIM: begin
        pronto        = 1'b1;
        w_prox_estado = INICIAL;
      end

      default: begin
        // Unused codes recover to the idle state on the next edge.
        w_prox_estado = INICIAL;
      end
    endcase
  end

  assign mem.endereco = r_endereco;
  assign db_estado    = r_estado;

endmodule
